// File: rtl/datmem_pkg.sv
// rtl/datmem_pkg.sv - shared types and constants for the data-memory arbiter
package datmem_pkg;
    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LD  = 1'b1;
    localparam int   BEATS   = 4;
endpackage

// File: rtl/datmem_arbiter_rr_arb2.sv
// rtl/datmem_arbiter_rr_arb2.sv - two-way round-robin / fixed-priority arbiter
module rr_arb2
    import datmem_pkg::*;
#(
    parameter int LD_PRIO = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_cpu,
    input  logic req_ld,
    output logic gnt_valid,
    output logic gnt
);
    logic last_grant;

    always_comb begin
        gnt_valid = req_cpu | req_ld;
        gnt       = GNT_CPU;
        if (req_cpu && req_ld) begin
            gnt = (LD_PRIO != 0) ? GNT_LD : ~last_grant;
        end else if (req_ld) begin
            gnt = GNT_LD;
        end
    end

    // Reset to LD so the CPU wins the very first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GNT_LD;
        end else if (en && gnt_valid) begin
            last_grant <= gnt;
        end
    end
endmodule

// File: rtl/datmem_arbiter.sv
// rtl/datmem_arbiter.sv - serialises CPU/LD word accesses into byte beats on a shared memory
module datmem_arbiter
    import datmem_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int LD_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic [31:0]       ld_rdata,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);
    state_t            state, state_nxt;
    logic [1:0]        beat;
    logic              gnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       rd_word;
    logic              arb_valid;
    logic              arb_gnt;

    rr_arb2 #(.LD_PRIO(LD_PRIO)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .en        (state == IDLE),
        .req_cpu   (cpu_req),
        .req_ld    (ld_req),
        .gnt_valid (arb_valid),
        .gnt       (arb_gnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_valid) state_nxt = BEAT;
            BEAT:    if (beat == 2'(BEATS - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-side outputs depend only on registered state, never on requester inputs.
    always_comb begin
        busy      = (state != IDLE);
        mem_we    = (state == BEAT) && lat_we;
        mem_addr  = (state == BEAT) ? lat_addr + ADDR_W'(beat) : '0;
        mem_wdata = mem_we ? lat_wdata[31:24] : 8'h00;
        cpu_ready = (state == DONE) && (gnt == GNT_CPU);
        ld_ready  = (state == DONE) && (gnt == GNT_LD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= 2'd0;
            gnt       <= GNT_CPU;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
            rd_word   <= 32'h0;
            cpu_rdata <= 32'h0;
            ld_rdata  <= 32'h0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        gnt       <= arb_gnt;
                        beat      <= 2'd0;
                        lat_we    <= (arb_gnt == GNT_LD) ? ld_we    : cpu_we;
                        lat_addr  <= (arb_gnt == GNT_LD) ? ld_addr  : cpu_addr;
                        lat_wdata <= (arb_gnt == GNT_LD) ? ld_wdata : cpu_wdata;
                    end
                end
                BEAT: begin
                    // Big-endian: shift write bytes out and read bytes in MSB first.
                    beat      <= beat + 2'd1;
                    lat_wdata <= lat_wdata << 8;
                    rd_word   <= {rd_word[23:0], mem_rdata};
                    if (beat == 2'(BEATS - 1) && !lat_we) begin
                        if (gnt == GNT_CPU) cpu_rdata <= {rd_word[23:0], mem_rdata};
                        else                ld_rdata  <= {rd_word[23:0], mem_rdata};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_datmem_arbiter.sv
// tb/tb_datmem_arbiter.sv - self-checking bench: instance 0 round-robin, instance 1 LD priority
module tb_datmem_arbiter;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          cpu_req[2], cpu_we[2], cpu_ready[2];
    logic [AW-1:0] cpu_addr[2];
    logic [31:0]   cpu_wdata[2], cpu_rdata[2];
    logic          ld_req[2], ld_we[2], ld_ready[2];
    logic [AW-1:0] ld_addr[2];
    logic [31:0]   ld_wdata[2], ld_rdata[2];
    logic [AW-1:0] mem_addr[2];
    logic          mem_we[2], busy[2];
    logic [7:0]    mem_wdata[2], mem_rdata[2];
    logic [7:0]    mem[2][DEPTH];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        datmem_arbiter #(.ADDR_W(AW), .LD_PRIO(g)) dut (
            .clk(clk), .reset(reset),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_rdata(cpu_rdata[g]), .cpu_ready(cpu_ready[g]),
            .ld_req(ld_req[g]), .ld_we(ld_we[g]), .ld_addr(ld_addr[g]),
            .ld_wdata(ld_wdata[g]), .ld_rdata(ld_rdata[g]), .ld_ready(ld_ready[g]),
            .mem_addr(mem_addr[g]), .mem_we(mem_we[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
    end

    always_comb for (int i = 0; i < 2; i++) mem_rdata[i] = mem[i][mem_addr[i]];
    always @(posedge clk) for (int i = 0; i < 2; i++) if (mem_we[i]) mem[i][mem_addr[i]] <= mem_wdata[i];

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1..4 byte beats, 5 ready; one word per grant.
    int            m_p[2];
    logic          m_port[2], m_we[2], m_last[2];
    logic [AW-1:0] m_addr[2];
    logic [31:0]   m_wdata[2], m_cpu_rd[2], m_ld_rd[2];
    logic [7:0]    ref_mem[2][DEPTH];
    logic          mw;
    logic [31:0]   mword;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_p[i] >= 1 && m_p[i] <= 4 && m_we[i])
                ref_mem[i][(int'(m_addr[i]) + m_p[i] - 1) % DEPTH] = m_wdata[i][8*(4-m_p[i]) +: 8];
            if (reset) begin
                m_p[i] = 0; m_last[i] = 1'b1; m_cpu_rd[i] = 32'h0; m_ld_rd[i] = 32'h0;
            end else if (m_p[i] == 0) begin
                if (cpu_req[i] || ld_req[i]) begin
                    if (cpu_req[i] && ld_req[i]) mw = (i == 1) ? 1'b1 : ~m_last[i];
                    else                         mw = ld_req[i];
                    m_port[i]  = mw;
                    m_last[i]  = mw;
                    m_we[i]    = mw ? ld_we[i]    : cpu_we[i];
                    m_addr[i]  = mw ? ld_addr[i]  : cpu_addr[i];
                    m_wdata[i] = mw ? ld_wdata[i] : cpu_wdata[i];
                    m_p[i]     = 1;
                end
            end else if (m_p[i] == 4) begin
                if (!m_we[i]) begin
                    for (int k = 0; k < 4; k++)
                        mword[8*(3-k) +: 8] = ref_mem[i][(int'(m_addr[i]) + k) % DEPTH];
                    if (m_port[i]) m_ld_rd[i] = mword; else m_cpu_rd[i] = mword;
                end
                m_p[i] = 5;
            end else if (m_p[i] == 5) begin
                m_p[i] = 0;
            end else begin
                m_p[i] = m_p[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic int p = m_p[i];
            automatic bit inb = (p >= 1 && p <= 4);
            check("busy", i, 32'(busy[i]), 32'(p != 0));
            check("mem_we", i, 32'(mem_we[i]), 32'(inb && m_we[i]));
            check("mem_addr", i, 32'(mem_addr[i]), inb ? 32'((int'(m_addr[i]) + p - 1) % DEPTH) : 32'h0);
            check("mem_wdata", i, 32'(mem_wdata[i]), (inb && m_we[i]) ? 32'(m_wdata[i][8*(4-p) +: 8]) : 32'h0);
            check("cpu_ready", i, 32'(cpu_ready[i]), 32'(p == 5 && !m_port[i]));
            check("ld_ready", i, 32'(ld_ready[i]), 32'(p == 5 && m_port[i]));
            check("cpu_rdata", i, cpu_rdata[i], m_cpu_rd[i]);
            check("ld_rdata", i, ld_rdata[i], m_ld_rd[i]);
        end
    end

    task automatic transact(input int i, input bit port, input bit we, input logic [AW-1:0] addr,
                            input logic [31:0] wdata, output int lat, output int nwe, output logic [31:0] rd);
        if (port) begin ld_req[i] = 1'b1; ld_we[i] = we; ld_addr[i] = addr; ld_wdata[i] = wdata; end
        else begin cpu_req[i] = 1'b1; cpu_we[i] = we; cpu_addr[i] = addr; cpu_wdata[i] = wdata; end
        lat = 0; nwe = 0; rd = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_we[i]) nwe++;
            if (port ? ld_ready[i] : cpu_ready[i]) begin
                lat = c;
                rd  = port ? ld_rdata[i] : cpu_rdata[i];
                break;
            end
        end
        if (port) ld_req[i] = 1'b0; else cpu_req[i] = 1'b0;
        @(negedge clk);
    endtask

    int          lat, nwe;
    logic [31:0] rd;
    int          rt[2][2][4];
    int          rn[2][2];
    logic [15:0] old23;
    int          nrdy;

    initial begin
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
            ld_req[i] = 0;  ld_we[i] = 0;  ld_addr[i] = '0;  ld_wdata[i] = '0;
            m_p[i] = 0; m_last[i] = 1'b1; m_cpu_rd[i] = 0; m_ld_rd[i] = 0;
            m_port[i] = 0; m_we[i] = 0; m_addr[i] = '0; m_wdata[i] = '0;
            for (int a = 0; a < DEPTH; a++) begin
                ref_mem[i][a] = 8'($urandom);
                mem[i][a] <= ref_mem[i][a];
            end
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        transact(0, 0, 1, 5'h04, 32'hDEADBEEF, lat, nwe, rd);
        check("t1_latency", 0, 32'(lat), 32'd5);
        check("t1_we_beats", 0, 32'(nwe), 32'd4);
        check("t1_bytes", 0, {mem[0][4], mem[0][5], mem[0][6], mem[0][7]}, 32'hDEADBEEF);

        transact(0, 1, 1, 5'h08, 32'h11223344, lat, nwe, rd);
        transact(0, 0, 0, 5'h08, 32'h0, lat, nwe, rd);
        check("t2_cpu_read", 0, rd, 32'h11223344);
        check("t2_ld_rdata_kept", 0, ld_rdata[0], 32'h0);

        transact(0, 0, 1, 5'h1E, 32'hA1B2C3D4, lat, nwe, rd);
        check("t3_wrap_bytes", 0, {mem[0][30], mem[0][31], mem[0][0], mem[0][1]}, 32'hA1B2C3D4);
        transact(0, 0, 0, 5'h1E, 32'h0, lat, nwe, rd);
        check("t3_wrap_read", 0, rd, 32'hA1B2C3D4);

        // Ties straight after reset: both ports held high on both instances.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rn[i][0] = 0; rn[i][1] = 0;
            cpu_req[i] = 1; cpu_we[i] = 0; cpu_addr[i] = 5'h10;
            ld_req[i] = 1;  ld_we[i] = 0;  ld_addr[i] = 5'h14;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (cpu_ready[i] && rn[i][0] < 4) begin rt[i][0][rn[i][0]] = c; rn[i][0]++; end
                if (ld_ready[i] && rn[i][1] < 4) begin rt[i][1][rn[i][1]] = c; rn[i][1]++; end
                if (i == 1 && ld_ready[i] && rn[i][1] == 2) ld_req[i] = 0;
                if (c >= 17) begin cpu_req[i] = 0; ld_req[i] = 0; end
            end
        end
        check("rr_cpu_count", 0, 32'(rn[0][0]), 32'd2);
        check("rr_ld_count", 0, 32'(rn[0][1]), 32'd1);
        check("rr_cpu_first", 0, 32'(rt[0][0][0]), 32'd5);
        check("rr_ld_second", 0, 32'(rt[0][1][0]), 32'd11);
        check("rr_cpu_third", 0, 32'(rt[0][0][1]), 32'd17);
        check("prio_ld_count", 1, 32'(rn[1][1]), 32'd2);
        check("prio_ld_first", 1, 32'(rt[1][1][0]), 32'd5);
        check("prio_ld_second", 1, 32'(rt[1][1][1]), 32'd11);
        check("prio_cpu_count", 1, 32'(rn[1][0]), 32'd1);
        check("prio_cpu_after_ld", 1, 32'(rt[1][0][0]), 32'd17);

        // Reset sampled on the edge that would start beat 2 of a write to address 0.
        old23 = {mem[0][2], mem[0][3]};
        cpu_req[0] = 1; cpu_we[0] = 1; cpu_addr[0] = 5'h00; cpu_wdata[0] = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cpu_req[0] = 0;
        check("rst_busy", 0, 32'(busy[0]), 32'd0);
        check("rst_mem_we", 0, 32'(mem_we[0]), 32'd0);
        nrdy = 0;
        repeat (8) begin
            @(negedge clk);
            if (cpu_ready[0]) nrdy++;
        end
        check("rst_no_ready", 0, 32'(nrdy), 32'd0);
        check("rst_bytes01", 0, 32'({mem[0][0], mem[0][1]}), 32'h0000CAFE);
        check("rst_bytes23", 0, 32'({mem[0][2], mem[0][3]}), 32'(old23));

        // Random traffic on both instances with occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 699) == 0);
            for (int i = 0; i < 2; i++) begin
                if (cpu_req[i] && cpu_ready[i]) cpu_req[i] = 0;
                else if (!cpu_req[i] && $urandom_range(0, 2) == 0) begin
                    cpu_req[i] = 1; cpu_we[i] = 1'($urandom);
                    cpu_addr[i] = AW'($urandom); cpu_wdata[i] = $urandom;
                end else if (cpu_req[i] && $urandom_range(0, 5) == 0) begin
                    cpu_addr[i] = AW'($urandom); cpu_wdata[i] = $urandom;
                end
                if (ld_req[i] && ld_ready[i]) ld_req[i] = 0;
                else if (!ld_req[i] && $urandom_range(0, 2) == 0) begin
                    ld_req[i] = 1; ld_we[i] = 1'($urandom);
                    ld_addr[i] = AW'($urandom); ld_wdata[i] = $urandom;
                end else if (ld_req[i] && $urandom_range(0, 5) == 0) begin
                    ld_addr[i] = AW'($urandom); ld_wdata[i] = $urandom;
                end
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin cpu_req[i] = 0; ld_req[i] = 0; end
        repeat (10) @(negedge clk);
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < DEPTH; a++)
                check("mem_contents", i, 32'(mem[i][a]), 32'(ref_mem[i][a]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end
endmodule
